// File: rtl/jpeg_pkg.sv
// Shared constants and types for the JPEG entropy-data path.
package jpeg_pkg;

  localparam logic [7:0] JPEG_MARKER_PREFIX = 8'hFF;
  localparam logic [7:0] JPEG_STUFF_BYTE    = 8'h00;

  localparam int BIT_WINDOW_WIDTH = 16;
  localparam int BIT_BUFFER_WIDTH = 32;

  typedef enum logic [1:0] {
    BR_IDLE,
    BR_FETCH,
    BR_DRAIN,
    BR_DONE
  } bit_reader_state_t;

endpackage

// File: rtl/byte_unstuffer.sv
// Removes 0xFF 0x00 stuffing from a byte stream and flags the first real marker.
module byte_unstuffer
  import jpeg_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic       clr,
  input  logic       in_valid,
  input  logic [7:0] in_byte,
  output logic       out_valid,
  output logic [7:0] out_byte,
  output logic       marker,
  output logic [7:0] marker_code,
  output logic       pending,
  output logic       pending_next
);

  logic pending_q;

  always_comb begin
    out_valid    = 1'b0;
    out_byte     = in_byte;
    marker       = 1'b0;
    pending_next = pending_q;
    if (in_valid) begin
      if (pending_q) begin
        if (in_byte == JPEG_STUFF_BYTE) begin
          out_valid    = 1'b1;
          out_byte     = JPEG_MARKER_PREFIX;
          pending_next = 1'b0;
        end else if (in_byte != JPEG_MARKER_PREFIX) begin
          // 0xFF 0xFF is a fill byte: stay pending until a real code arrives
          marker       = 1'b1;
          pending_next = 1'b0;
        end
      end else if (in_byte == JPEG_MARKER_PREFIX) begin
        pending_next = 1'b1;
      end else begin
        out_valid = 1'b1;
      end
    end
  end

  assign marker_code = in_byte;
  assign pending     = pending_q;

  always_ff @(posedge clk) begin
    if (rst || clr) pending_q <= 1'b0;
    else            pending_q <= pending_next;
  end

endmodule

// File: rtl/ram_bit_reader.sv
// Reads scan bytes from RAM, unstuffs them and serves an MSB-first bit window.
//   state    | meaning
//   BR_IDLE  | waiting for start
//   BR_FETCH | issuing RAM reads, filling the bit buffer
//   BR_DRAIN | no more reads; downstream consumes what is left
//   BR_DONE  | buffer empty, scan finished
module ram_bit_reader
  import jpeg_pkg::*;
#(
  parameter int ADDRESS_WIDTH = 16
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     start,
  input  logic [ADDRESS_WIDTH-1:0] start_address,
  input  logic [ADDRESS_WIDTH-1:0] end_address,
  output logic                     ram_ce,
  output logic [ADDRESS_WIDTH-1:0] ram_address,
  input  logic [7:0]               ram_data,
  output logic [15:0]              bits_out,
  output logic [5:0]               bits_available,
  input  logic                     consume,
  input  logic [4:0]               consume_count,
  output logic                     busy,
  output logic                     done,
  output logic                     marker_found,
  output logic [7:0]               marker_code,
  output logic                     error
);

  localparam logic [ADDRESS_WIDTH:0] ADDR_ONE = 1;

  bit_reader_state_t state_q, state_d;

  logic [BIT_BUFFER_WIDTH-1:0] shift_q, shift_d, shift_consumed;
  logic [5:0]                  fill_q, fill_d, fill_consumed;
  logic [6:0]                  fill_ahead;
  logic [ADDRESS_WIDTH:0]      next_addr_q;
  logic [ADDRESS_WIDTH-1:0]    end_q, ram_address_q;
  logic                        ram_ce_q, rd_valid_q;
  logic                        error_q, marker_found_q;
  logic [7:0]                  marker_code_q;
  logic                        consume_ok, consume_bad, past_end, issue, dangling;

  logic       us_in_valid, us_out_valid, us_marker, us_pending, us_pending_next;
  logic [7:0] us_out_byte, us_marker_code;

  assign us_in_valid = rd_valid_q && (state_q == BR_FETCH);

  byte_unstuffer u_unstuffer (
    .clk          (clk),
    .rst          (rst),
    .clr          (start),
    .in_valid     (us_in_valid),
    .in_byte      (ram_data),
    .out_valid    (us_out_valid),
    .out_byte     (us_out_byte),
    .marker       (us_marker),
    .marker_code  (us_marker_code),
    .pending      (us_pending),
    .pending_next (us_pending_next)
  );

  always_comb begin
    consume_ok  = consume && (consume_count != 5'd0) && (consume_count <= 5'd16)
                  && ({1'b0, consume_count} <= fill_q);
    consume_bad = consume && !consume_ok;

    shift_consumed = consume_ok ? (shift_q << consume_count) : shift_q;
    fill_consumed  = consume_ok ? (fill_q - {1'b0, consume_count}) : fill_q;

    shift_d = shift_consumed;
    fill_d  = fill_consumed;
    if (us_out_valid) begin
      shift_d = shift_consumed
                | ({us_out_byte, {(BIT_BUFFER_WIDTH-8){1'b0}}} >> fill_consumed);
      fill_d  = fill_consumed + 6'd8;
    end

    past_end   = next_addr_q > {1'b0, end_q};
    fill_ahead = {1'b0, fill_d} + (ram_ce_q ? 7'd8 : 7'd0);
    // With an 0xFF pending and its successor already in flight, hold off so
    // nothing past a marker is ever read.
    issue = (state_q == BR_FETCH) && !past_end && !us_marker
            && !(us_pending_next && ram_ce_q) && (fill_ahead <= 7'd24);
    dangling = (state_q == BR_FETCH) && past_end && !ram_ce_q && !rd_valid_q
               && us_pending;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      BR_IDLE, BR_DONE: state_d = state_q;
      BR_FETCH:
        if (us_marker || (past_end && !ram_ce_q && !rd_valid_q)) state_d = BR_DRAIN;
      BR_DRAIN:
        if (fill_q == 6'd0) state_d = BR_DONE;
      default: state_d = BR_IDLE;
    endcase
    if (start) state_d = BR_FETCH;
  end

  always_ff @(posedge clk) begin
    if (rst) state_q <= BR_IDLE;
    else     state_q <= state_d;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      shift_q        <= '0;
      fill_q         <= '0;
      next_addr_q    <= '0;
      end_q          <= '0;
      ram_address_q  <= '0;
      ram_ce_q       <= 1'b0;
      rd_valid_q     <= 1'b0;
      error_q        <= 1'b0;
      marker_found_q <= 1'b0;
      marker_code_q  <= '0;
    end else if (start) begin
      shift_q        <= '0;
      fill_q         <= '0;
      rd_valid_q     <= 1'b0;
      error_q        <= 1'b0;
      marker_found_q <= 1'b0;
      marker_code_q  <= '0;
      end_q          <= end_address;
      if (start_address <= end_address) begin
        ram_ce_q      <= 1'b1;
        ram_address_q <= start_address;
        next_addr_q   <= {1'b0, start_address} + ADDR_ONE;
      end else begin
        ram_ce_q    <= 1'b0;
        next_addr_q <= {1'b0, start_address};
      end
    end else begin
      shift_q    <= shift_d;
      fill_q     <= fill_d;
      rd_valid_q <= ram_ce_q;
      ram_ce_q   <= issue;
      if (issue) begin
        ram_address_q <= next_addr_q[ADDRESS_WIDTH-1:0];
        next_addr_q   <= next_addr_q + ADDR_ONE;
      end
      if (consume_bad || dangling) error_q <= 1'b1;
      if (us_marker) begin
        marker_found_q <= 1'b1;
        marker_code_q  <= us_marker_code;
      end
    end
  end

  assign ram_ce         = ram_ce_q;
  assign ram_address    = ram_address_q;
  assign bits_out       = shift_q[BIT_BUFFER_WIDTH-1 -: BIT_WINDOW_WIDTH];
  assign bits_available = fill_q;
  assign busy           = (state_q == BR_FETCH) || (state_q == BR_DRAIN);
  assign done           = (state_q == BR_DONE);
  assign marker_found   = marker_found_q;
  assign marker_code    = marker_code_q;
  assign error          = error_q;

endmodule

// File: tb/tb_ram_bit_reader.sv
// Bench for ram_bit_reader: bit-stream model from unstuffing rules, random and directed scans.
module tb_ram_bit_reader;

  logic        clk = 1'b0;
  logic        rst, start, consume;
  logic [15:0] start_address, end_address, ram_address;
  logic        ram_ce;
  logic [7:0]  ram_data;
  logic [15:0] bits_out;
  logic [5:0]  bits_available;
  logic [4:0]  consume_count;
  logic        busy, done, marker_found, error;
  logic [7:0]  marker_code;

  always #5 clk = ~clk;

  ram_bit_reader #(.ADDRESS_WIDTH(16)) dut (
    .clk            (clk),
    .rst            (rst),
    .start          (start),
    .start_address  (start_address),
    .end_address    (end_address),
    .ram_ce         (ram_ce),
    .ram_address    (ram_address),
    .ram_data       (ram_data),
    .bits_out       (bits_out),
    .bits_available (bits_available),
    .consume        (consume),
    .consume_count  (consume_count),
    .busy           (busy),
    .done           (done),
    .marker_found   (marker_found),
    .marker_code    (marker_code),
    .error          (error)
  );

  logic [7:0] mem [0:255];
  always @(posedge clk) if (ram_ce) ram_data <= mem[ram_address[7:0]];

  int n_pass = 0;
  int n_total = 0;

  task automatic check(string name, bit ok, longint act, longint req);
    n_total++;
    if (ok) n_pass++;
    else $display("FAIL %s: got %0h, required %0h", name, act, req);
  endtask

  // Reference: the expected unstuffed bit stream and how far downstream has eaten into it.
  bit         exp_q[$];
  int         consumed = 0;
  bit         exp_marker, exp_err;
  logic [7:0] exp_code;
  int         lo_addr, hi_addr;
  bit         checking = 0;
  bit         consume_legal = 0;

  task automatic push_byte(logic [7:0] b);
    for (int i = 7; i >= 0; i--) exp_q.push_back(b[i]);
  endtask

  task automatic build_model(int sa, int ea);
    bit pend;
    logic [7:0] b;
    exp_q.delete();
    pend = 0; exp_marker = 0; exp_code = 0; exp_err = 0;
    lo_addr = sa; hi_addr = ea;
    for (int a = sa; a <= ea; a++) begin
      b = mem[a];
      if (pend) begin
        if (b == 8'h00) begin
          push_byte(8'hFF);
          pend = 0;
        end else if (b != 8'hFF) begin
          exp_marker = 1; exp_code = b; hi_addr = a; pend = 0;
          break;
        end
      end else if (b == 8'hFF) pend = 1;
      else push_byte(b);
    end
    exp_err = pend;
    consumed = 0;
  endtask

  always @(posedge clk) if (consume && consume_legal) consumed = consumed + int'(consume_count);

  always @(negedge clk) begin : compare
    logic [15:0] w;
    int avail, remain;
    if (checking) begin
      avail  = int'(bits_available);
      remain = exp_q.size() - consumed;
      w = '0;
      for (int i = 0; i < 16; i++)
        if (i < avail && i < remain) w[15-i] = exp_q[consumed+i];
      check("bits_out", bits_out == w, bits_out, w);
      check("bits_available_bound", avail <= remain && avail <= 32, avail, remain);
      if (ram_ce)
        check("read_address", int'(ram_address) >= lo_addr && int'(ram_address) <= hi_addr,
              ram_address, hi_addr);
      if (!exp_err) check("error_low", error == 1'b0, error, 0);
      if (!exp_marker) check("marker_low", marker_found == 1'b0, marker_found, 0);
    end
  end

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic start_scan(int sa, int ea);
    checking = 0;
    start = 1; start_address = 16'(sa); end_address = 16'(ea);
    build_model(sa, ea);
    tick();
    start = 0;
    checking = 1;
  endtask

  task automatic do_consume(int c, bit legal);
    consume = 1; consume_count = 5'(c); consume_legal = legal;
    tick();
    consume = 0; consume_legal = 0;
  endtask

  task automatic finish_scan(int pct);
    int cyc, c, avail;
    cyc = 0;
    while (!done && cyc < 3000) begin
      avail = int'(bits_available);
      if (avail > 0 && $urandom_range(99) < pct) begin
        c = $urandom_range(avail < 16 ? avail : 16, 1);
        do_consume(c, 1);
      end else tick();
      cyc++;
    end
    check("scan_done", done == 1'b1, done, 1);
    check("consumed_all", consumed == exp_q.size(), consumed, exp_q.size());
    check("marker_found", marker_found == exp_marker, marker_found, exp_marker);
    if (exp_marker) check("marker_code", marker_code == exp_code, marker_code, exp_code);
    check("error_final", error == exp_err, error, exp_err);
    check("busy_low", busy == 1'b0, busy, 0);
  endtask

  task automatic reset_check(string name);
    logic [50:0] v;
    v = {ram_ce, ram_address, bits_out, bits_available, busy, done,
         marker_found, marker_code, error};
    check(name, v == '0, v, 0);
  endtask

  initial begin
    int lat, sa, len, r;
    rst = 1; start = 0; consume = 0; consume_count = 0;
    start_address = 0; end_address = 0;
    for (int a = 0; a < 256; a++) mem[a] = 8'($urandom);
    tick(); tick();
    reset_check("reset_values");
    rst = 0;
    tick();

    // 12 34 56, no consume, then 16 + 8
    mem[0] = 8'h12; mem[1] = 8'h34; mem[2] = 8'h56;
    start_scan(0, 2);
    check("model_len_3bytes", exp_q.size() == 24, exp_q.size(), 24);
    lat = 1;
    while (bits_available == 0 && lat < 10) begin tick(); lat++; end
    check("first_fill_latency", lat == 3, lat, 3);
    repeat (8) tick();
    check("t1_avail", bits_available == 6'd24, bits_available, 24);
    check("t1_bits", bits_out == 16'h1234, bits_out, 16'h1234);
    check("t1_busy_drain", busy == 1'b1 && done == 1'b0, {busy, done}, 2'b10);
    do_consume(16, 1);
    check("t1_avail_after16", bits_available == 6'd8, bits_available, 8);
    check("t1_bits_after16", bits_out == 16'h5600, bits_out, 16'h5600);
    do_consume(8, 1);
    check("t1_avail_empty", bits_available == 6'd0, bits_available, 0);
    tick();
    check("t1_done", done == 1'b1 && busy == 1'b0, {done, busy}, 2'b10);

    // AB FF 00 CD
    mem[10] = 8'hAB; mem[11] = 8'hFF; mem[12] = 8'h00; mem[13] = 8'hCD;
    start_scan(10, 13);
    repeat (12) tick();
    check("t2_avail", bits_available == 6'd24, bits_available, 24);
    check("t2_bits", bits_out == 16'hABFF, bits_out, 16'hABFF);
    finish_scan(60);

    // 11 FF D9 22
    mem[20] = 8'h11; mem[21] = 8'hFF; mem[22] = 8'hD9; mem[23] = 8'h22;
    start_scan(20, 23);
    repeat (12) tick();
    check("t3_avail", bits_available == 6'd8, bits_available, 8);
    check("t3_marker", marker_found == 1'b1, marker_found, 1);
    check("t3_code", marker_code == 8'hD9, marker_code, 8'hD9);
    check("t3_bits", bits_out == 16'h1100, bits_out, 16'h1100);
    do_consume(8, 1);
    tick();
    check("t3_done", done == 1'b1, done, 1);

    // F0 0F, consume 4 whenever possible
    mem[30] = 8'hF0; mem[31] = 8'h0F;
    start_scan(30, 31);
    for (int cyc = 0; cyc < 40 && !done; cyc++) begin
      if (bits_available >= 6'd4) do_consume(4, 1);
      else tick();
    end
    check("t4_done", done == 1'b1, done, 1);
    check("t4_consumed", consumed == 16, consumed, 16);

    // illegal consume
    mem[40] = 8'h5A;
    start_scan(40, 40);
    repeat (8) tick();
    check("t5_avail", bits_available == 6'd8, bits_available, 8);
    exp_err = 1;
    do_consume(12, 0);
    check("t5_error", error == 1'b1, error, 1);
    check("t5_avail_kept", bits_available == 6'd8, bits_available, 8);
    check("t5_bits_kept", bits_out == 16'h5A00, bits_out, 16'h5A00);
    do_consume(8, 1);
    tick();
    check("t5_done", done == 1'b1, done, 1);

    // reset with a read in flight, then a clean restart
    start_scan(0, 9);
    check("t6_error_cleared", error == 1'b0, error, 0);
    tick();
    check("t6_read_in_flight", ram_ce == 1'b1, ram_ce, 1);
    checking = 0;
    rst = 1;
    tick();
    reset_check("t6_reset_values");
    rst = 0;
    start_scan(0, 2);
    finish_scan(50);

    // randomized scans
    for (int s = 0; s < 30; s++) begin
      sa  = $urandom_range(200);
      len = $urandom_range(40, 1);
      for (int a = sa; a < sa + len; a++) begin
        r = $urandom_range(99);
        mem[a] = (r < 15) ? 8'hFF : (r < 25) ? 8'h00 : 8'($urandom);
      end
      start_scan(sa, sa + len - 1);
      finish_scan($urandom_range(90, 30));
    end

    checking = 0;
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/ram_bit_reader.md
# ram_bit_reader

Fetches entropy-coded JPEG scan bytes from the generic byte RAM, strips `0xFF 0x00` byte stuffing, stops at the first real marker, and presents an MSB-first bit window to the downstream Huffman decoder. It sits between the RAM's read port and the Huffman stage. It owns the RAM's `CE`/`address` while busy; the RAM's `WE` is tied low.

## Interface
- `ADDRESS_WIDTH`, 16, RAM address width
- `clk`  in  1  clock, rising edge
- `rst`  in  1  reset, synchronous, active-high
- `start`  in  1  one-cycle pulse; latches `start_address`/`end_address`, clears buffer, begins fetch
- `start_address`  in  ADDRESS_WIDTH  first scan byte address
- `end_address`  in  ADDRESS_WIDTH  last scan byte address, inclusive
- `ram_ce`  out  1  RAM chip enable (read request)
- `ram_address`  out  ADDRESS_WIDTH  RAM address
- `ram_data`  in  8  RAM `data_output`, valid one cycle after `ram_ce`
- `bits_out`  out  16  next 16 buffered bits, left-aligned, zero-padded below `bits_available`
- `bits_available`  out  6  buffered bit count, saturated at 32
- `consume`  in  1  strobe; drop `consume_count` bits this cycle
- `consume_count`  in  5  1..16
- `busy`  out  1  high from `start` until `done`
- `done`  out  1  level; fetch finished and buffer empty; cleared by `start`
- `marker_found`  out  1  level; non-stuffed marker seen
- `marker_code`  out  8  byte following the `0xFF`; valid while `marker_found`
- `error`  out  1  sticky until `start`/`rst`; illegal consume or dangling `0xFF`

## Operation
- Reset: `ram_ce=0`, `ram_address=0`, `bits_out=0`, `bits_available=0`, `busy=0`, `done=0`, `marker_found=0`, `marker_code=0`, `error=0`, state IDLE, in-flight flag cleared.
- States:
  - IDLE: `start` → FETCH.
  - FETCH: stop condition reached → DRAIN.
  - DRAIN: `bits_available==0` → DONE.
  - DONE: `start` → FETCH.
- `start` in any state restarts: buffer, flags and in-flight read discarded.
- Stop condition (FETCH→DRAIN): address past `end_address`, or marker detected.
- Fetch rule: in FETCH, issue a read when `fill + 8*inflight <= 24`, counting the current cycle's consume. Address increments per read.
- Bit buffer: 32 bits.
  - `fill_next = fill - (consume ? consume_count : 0) + (byte_appended ? 8 : 0)`.
  - Consume and append in the same cycle are both honoured.
- Unstuffing (sub-module):
  - `0xFF` is held pending, not appended.
  - `0xFF` then `0x00`: append `0xFF` only.
  - `0xFF` then any other byte X: append nothing, set `marker_found`, `marker_code=X`, enter DRAIN.
  - `0xFF` then `0xFF`: treat as fill byte and keep pending.
  - `0xFF` at `end_address`: set `error`, enter DRAIN.
- Illegal consume (`consume_count==0`, `>16`, or `>bits_available`): buffer unchanged, `error` set.
- Buffered bits before a marker remain consumable in DRAIN.

## Timing
- Read latency: byte appended to buffer in the cycle after `ram_ce`; visible on `bits_out` the cycle after that.
- First `bits_available>0` occurs 3 cycles after `start`.
- Throughput: one RAM byte per cycle while the fetch rule allows.
- `bits_out`/`bits_available` are registered and reflect consume on the next cycle.
- `done` rises the cycle after `bits_available` reaches 0 in DRAIN. `busy` falls the same cycle.
- `rst` mid-scan: next cycle all outputs are at reset values. A RAM byte arriving from a pre-reset read is dropped.

## Structure
- Shared package `jpeg_pkg`:
  - `JPEG_MARKER_PREFIX=8'hFF`, `JPEG_STUFF_BYTE=8'h00`
  - bit-window width 16, buffer width 32
  - state enum `bit_reader_state_t`
- One sub-module, `byte_unstuffer`: byte in/valid → byte out/valid, marker/marker_code, pending-`0xFF` register.
- Address counter, buffer and FSM stay in `ram_bit_reader`.

## Test plan
- RAM `12 34 56` at 0..2, no consume → `bits_available=24`, `bits_out=16'h1234`, DRAIN; consume 24 bits in 16+8 → `done=1`.
- Bytes `AB FF 00 CD` → buffered stream `AB FF CD`, `bits_available=24`, no marker.
- Bytes `11 FF D9 22` → `bits_available=8`, `marker_found=1`, `marker_code=D9`, address 3 never read; consume 8 → `done`.
- Stream `F0 0F`, consume 4 each cycle while fetching → `bits_out` sequence `F00F`, `00F0`, `0F00`…; no lost or duplicated bits.
- `bits_available=8`, consume 12 → `error=1`, `bits_available` stays 8; `start` clears `error`.
- `rst` asserted two cycles after `start` with a read in flight → all outputs at reset values next cycle; later `start` at address 0 yields a correct stream.
